// File: rtl/dma_desc_pkg.sv
// Shared types and constants for the descriptor DMA front end.
package dma_desc_pkg;

    // Fetcher control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        OUT   = 2'd2,
        WRITE = 2'd3
    } fetcher_state_e;

    // Default descriptor length in register words
    localparam int unsigned DescNumWords = 4;

    // Bit value replicated across the completion word ('1 at any width)
    localparam bit DescDoneValue = 1'b1;

    // Default register-interface request (64-bit address and data)
    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } dma_reg_req_t;

    // Default register-interface response
    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } dma_reg_rsp_t;

endpackage

// File: rtl/dma_desc_reg_fetcher.sv
// Descriptor fetch engine: reads NumWords sequential register words from a
// base address, presents them as one descriptor, and issues all-ones
// completion writes on request.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Once a request is raised (reg_req_o.valid, desc_valid_o) it
// and its payload stay constant until ready is seen; only reset may drop it.
module dma_desc_reg_fetcher
    import dma_desc_pkg::*;
#(
    parameter type         reg_req_t              = dma_reg_req_t,
    parameter type         reg_rsp_t              = dma_reg_rsp_t,
    parameter int unsigned AddrWidth              = 64,
    parameter int unsigned DataWidth              = 64,
    parameter int unsigned ByteWidthInPowersOfTwo = 3,
    parameter int unsigned NumWords               = DescNumWords
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          addr_valid_i,
    output logic                          addr_ready_o,
    input  logic [AddrWidth-1:0]          addr_i,
    output logic                          desc_valid_o,
    input  logic                          desc_ready_i,
    output logic [NumWords*DataWidth-1:0] desc_o,
    input  logic                          done_valid_i,
    output logic                          done_ready_o,
    input  logic [AddrWidth-1:0]          done_addr_i,
    output logic                          busy_o,
    output reg_req_t                      reg_req_o,
    input  reg_rsp_t                      reg_rsp_i
);

    localparam int unsigned CntWidth  = $clog2(NumWords + 1);
    localparam int unsigned DescWidth = NumWords * DataWidth;
    // Clears the byte-offset bits so the base is word aligned
    localparam logic [AddrWidth-1:0] AlignMask =
        ~((AddrWidth'(1) << ByteWidthInPowersOfTwo) - AddrWidth'(1));

    fetcher_state_e        state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [AddrWidth-1:0]  base_q, base_d;
    logic [AddrWidth-1:0]  done_addr_q, done_addr_d;
    logic [DescWidth-1:0]  desc_q, desc_d;

    // The slave's error flag carries no meaning for this block
    logic unused_rsp_error;
    assign unused_rsp_error = reg_rsp_i.error;

    assign desc_o = desc_q;

    // State register and datapath registers, async active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            done_addr_q <= '0;
            desc_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            done_addr_q <= done_addr_d;
            desc_q      <= desc_d;
        end
    end

    // Next-state logic and output decode; request fields depend only on state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        done_addr_d  = done_addr_q;
        desc_d       = desc_q;
        addr_ready_o = 1'b0;
        done_ready_o = 1'b0;
        desc_valid_o = 1'b0;
        busy_o       = (state_q != IDLE);
        reg_req_o    = '0;

        case (state_q)
            IDLE: begin
                // A pending completion write wins over a new fetch
                done_ready_o = done_valid_i;
                addr_ready_o = !done_valid_i;
                if (done_valid_i) begin
                    done_addr_d = done_addr_i;
                    state_d     = WRITE;
                end else if (addr_valid_i) begin
                    base_d  = addr_i & AlignMask;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b0;
                // Address arithmetic wraps modulo 2^AddrWidth
                reg_req_o.addr  = base_q + (AddrWidth'(cnt_q) << ByteWidthInPowersOfTwo);
                if (reg_rsp_i.ready) begin
                    desc_d[cnt_q*DataWidth +: DataWidth] = reg_rsp_i.rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntWidth'(NumWords - 1)) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.addr  = done_addr_q;
                reg_req_o.wdata = {DataWidth{DescDoneValue}};
                reg_req_o.wstrb = '1;
                if (reg_rsp_i.ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_desc_reg_fetcher.sv
// Bench for dma_desc_reg_fetcher: table of fetch vectors plus directed
// sequences for back-pressure, completion priority and mid-fetch reset.
module tb_dma_desc_reg_fetcher;
    import dma_desc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         addr_valid, addr_ready;
    logic [63:0]  addr_in;
    logic         desc_valid, desc_ready;
    logic [255:0] desc;
    logic         done_valid, done_ready;
    logic [63:0]  done_addr;
    logic         busy;
    dma_reg_req_t req;
    dma_reg_rsp_t rsp;

    dma_desc_reg_fetcher #(
        .reg_req_t              (dma_reg_req_t),
        .reg_rsp_t              (dma_reg_rsp_t),
        .AddrWidth              (64),
        .DataWidth              (64),
        .ByteWidthInPowersOfTwo (3),
        .NumWords               (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .addr_valid_i (addr_valid),
        .addr_ready_o (addr_ready),
        .addr_i       (addr_in),
        .desc_valid_o (desc_valid),
        .desc_ready_i (desc_ready),
        .desc_o       (desc),
        .done_valid_i (done_valid),
        .done_ready_o (done_ready),
        .done_addr_i  (done_addr),
        .busy_o       (busy),
        .reg_req_o    (req),
        .reg_rsp_i    (rsp)
    );

    // ---------------- memory slave model ----------------
    logic [63:0] wait_addr;
    int          wait_n;
    int          stall_cnt;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        case (a)
            64'h1000: mem_rd = 64'h11;
            64'h1008: mem_rd = 64'h22;
            64'h1010: mem_rd = 64'h33;
            64'h1018: mem_rd = 64'h44;
            64'hFFFF_FFFF_FFFF_FFF8: mem_rd = 64'hA1;
            64'h0000: mem_rd = 64'hB2;
            64'h0008: mem_rd = 64'hC3;
            64'h0010: mem_rd = 64'hD4;
            64'h3000: mem_rd = 64'h0123_4567_89AB_CDEF;
            64'h3008: mem_rd = 64'hFEDC_BA98_7654_3210;
            64'h3010: mem_rd = 64'h0;
            64'h3018: mem_rd = 64'hFFFF_FFFF_FFFF_FFFF;
            default:  mem_rd = 64'hDEAD_0000_0000_0000 | a;
        endcase
    endfunction

    // Slave answers in the same cycle unless told to stall on wait_addr
    always_comb begin
        rsp       = '0;
        rsp.rdata = mem_rd(req.addr);
        rsp.ready = req.valid && !((req.addr == wait_addr) && (stall_cnt < wait_n));
    end

    // ---------------- monitor ----------------
    logic [63:0]  rd_q[$];
    logic [63:0]  wr_addr_q[$];
    logic [63:0]  wr_data_q[$];
    logic [7:0]   wr_strb_q[$];
    int           unstable_cnt;
    logic         stall_prev;
    dma_reg_req_t req_prev;

    // Logs handshakes and flags any request change while stalled
    always @(posedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
            stall_cnt  <= 0;
        end else begin
            if (stall_prev && (req != req_prev)) unstable_cnt <= unstable_cnt + 1;
            stall_prev <= req.valid && !rsp.ready;
            req_prev   <= req;
            if (req.valid && !rsp.ready) stall_cnt <= stall_cnt + 1;
            if (req.valid && rsp.ready) begin
                stall_cnt <= 0;
                if (req.write) begin
                    wr_addr_q.push_back(req.addr);
                    wr_data_q.push_back(req.wdata);
                    wr_strb_q.push_back(req.wstrb);
                end else begin
                    rd_q.push_back(req.addr);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0]       base;
        logic [63:0]       wait_addr;
        int                wait_n;
        logic [3:0][63:0]  addrs;
        logic [255:0]      desc;
        int                cyc;
    } vec_t;

    vec_t vecs[5];

    // Runs one fetch and checks addresses, latency, data and stability
    task automatic run_fetch(input vec_t v, input string nm, input bit consume);
        int start, u0, cyc;
        wait_addr = v.wait_addr;
        wait_n    = v.wait_n;
        start     = rd_q.size();
        u0        = unstable_cnt;
        @(negedge clk);
        addr_in    = v.base;
        addr_valid = 1'b1;
        chk({nm, " addr_ready"}, 256'(addr_ready), 256'd1);
        @(posedge clk);
        #1 addr_valid = 1'b0;
        cyc = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (desc_valid) break;
            cyc++;
        end
        chk({nm, " desc_valid"}, 256'(desc_valid), 256'd1);
        chk({nm, " latency"}, 256'(cyc), 256'(v.cyc));
        chk({nm, " desc"}, desc, v.desc);
        chk({nm, " nreads"}, 256'(rd_q.size() - start), 256'd4);
        for (int k = 0; k < 4; k++) begin
            if (start + k < rd_q.size())
                chk($sformatf("%s rd_addr%0d", nm, k), 256'(rd_q[start+k]), 256'(v.addrs[k]));
        end
        chk({nm, " req_stable"}, 256'(unstable_cnt - u0), 256'd0);
        if (consume) begin
            desc_ready = 1'b1;
            @(posedge clk);
            #1 desc_ready = 1'b0;
            @(negedge clk);
            chk({nm, " idle_after"}, 256'(busy), 256'd0);
        end
        wait_n = 0;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [63:0] ones64;
        logic [255:0] d0;
        int n0;
        ones64 = '1;

        vecs[0] = '{64'h1000, 64'h0, 0, {64'h1018, 64'h1010, 64'h1008, 64'h1000},
                    {64'h44, 64'h33, 64'h22, 64'h11}, 5};
        vecs[1] = '{64'h1000, 64'h1008, 2, {64'h1018, 64'h1010, 64'h1008, 64'h1000},
                    {64'h44, 64'h33, 64'h22, 64'h11}, 7};
        vecs[2] = '{64'h1003, 64'h0, 0, {64'h1018, 64'h1010, 64'h1008, 64'h1000},
                    {64'h44, 64'h33, 64'h22, 64'h11}, 5};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, {64'h10, 64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8},
                    {64'hD4, 64'hC3, 64'hB2, 64'hA1}, 5};
        vecs[4] = '{64'h3000, 64'h3018, 1, {64'h3018, 64'h3010, 64'h3008, 64'h3000},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 6};

        rst_n        = 1'b0;
        addr_valid   = 1'b0;
        addr_in      = '0;
        desc_ready   = 1'b0;
        done_valid   = 1'b0;
        done_addr    = '0;
        wait_addr    = '0;
        wait_n       = 0;
        unstable_cnt = 0;

        // Reset state
        #3;
        chk("rst desc_valid", 256'(desc_valid), 256'd0);
        chk("rst busy", 256'(busy), 256'd0);
        chk("rst reg_req", 256'(req), 256'd0);
        chk("rst desc", desc, 256'd0);
        chk("rst addr_ready", 256'(addr_ready), 256'd1);
        chk("rst done_ready", 256'(done_ready), 256'd0);
        done_valid = 1'b1;
        #1;
        chk("rst done_ready hi", 256'(done_ready), 256'd1);
        chk("rst addr_ready lo", 256'(addr_ready), 256'd0);
        done_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fetches
        for (int i = 0; i < 5; i++) begin
            run_fetch(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Consumer back-pressure for 10 cycles
        run_fetch(vecs[0], "hold", 1'b0);
        d0 = desc;
        n0 = rd_q.size();
        addr_in    = 64'h3000;
        addr_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk($sformatf("hold desc%0d", t), desc, d0);
            chk($sformatf("hold addr_ready%0d", t), 256'(addr_ready), 256'd0);
            chk($sformatf("hold valid%0d", t), 256'({desc_valid, req.valid}), 256'b10);
        end
        addr_valid = 1'b0;
        chk("hold no reads", 256'(rd_q.size() - n0), 256'd0);
        desc_ready = 1'b1;
        @(posedge clk);
        #1 desc_ready = 1'b0;
        @(negedge clk);
        chk("hold release idle", 256'(busy), 256'd0);

        // Completion request wins over a simultaneous fetch request
        n0 = rd_q.size();
        @(negedge clk);
        done_valid = 1'b1;
        done_addr  = 64'h2008;
        addr_valid = 1'b1;
        addr_in    = 64'h1000;
        #1;
        chk("both done_ready", 256'(done_ready), 256'd1);
        chk("both addr_ready", 256'(addr_ready), 256'd0);
        @(posedge clk);
        #1 done_valid = 1'b0;
        @(negedge clk);
        chk("wr valid/write", 256'({req.valid, req.write}), 256'b11);
        chk("wr addr", 256'(req.addr), 256'h2008);
        chk("wr data", 256'(req.wdata), 256'(ones64));
        chk("wr strb", 256'(req.wstrb), 256'hFF);
        addr_valid = 1'b0;
        @(negedge clk);
        chk("wr idle", 256'(busy), 256'd0);
        chk("wr count", 256'(wr_addr_q.size()), 256'd1);
        if (wr_addr_q.size() > 0) begin
            chk("wr log addr", 256'(wr_addr_q[0]), 256'h2008);
            chk("wr log data", 256'(wr_data_q[0]), 256'(ones64));
            chk("wr log strb", 256'(wr_strb_q[0]), 256'hFF);
        end
        chk("wr no reads", 256'(rd_q.size() - n0), 256'd0);
        run_fetch(vecs[0], "after_wr", 1'b1);

        // Reset while reading word 2
        wait_addr = 64'h1010;
        wait_n    = 3;
        @(negedge clk);
        addr_in    = 64'h1000;
        addr_valid = 1'b1;
        @(posedge clk);
        #1 addr_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req.valid && req.addr == 64'h1010) break;
        end
        chk("mid word2 reached", 256'(req.addr), 256'h1010);
        rst_n = 1'b0;
        #1;
        chk("mid rst req.valid", 256'(req.valid), 256'd0);
        chk("mid rst busy", 256'(busy), 256'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        wait_n = 0;
        @(negedge clk);
        chk("post rst busy", 256'(busy), 256'd0);
        chk("post rst desc", desc, 256'd0);
        run_fetch(vecs[0], "post_rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_desc_reg_fetcher.md
# dma_desc_reg_fetcher

Descriptor fetch engine for the CVA6 descriptor-based DMA system. It sits directly upstream of the register-to-AXI bridge. It accepts a descriptor base address, issues sequential single-word register-interface reads to fetch a fixed-size descriptor, and presents the assembled descriptor on a valid/ready output. On request, it also issues a single completion write of all-ones to a given address, so the front end can flag finished descriptors in memory.

## Interface
Parameters:
- reg_req_t, logic: register-interface request struct (addr, write, wdata, wstrb, valid).
- reg_rsp_t, logic: register-interface response struct (rdata, error, ready).
- AddrWidth, 64: address width.
- DataWidth, 64: register data width; must equal 8 << ByteWidthInPowersOfTwo.
- ByteWidthInPowersOfTwo, 3: log2 of bytes per word.
- NumWords, 4: descriptor length in words; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- addr_valid_i  in  1  descriptor base address valid.
- addr_ready_o  out  1  base address accepted.
- addr_i  in  AddrWidth  descriptor base byte address.
- desc_valid_o  out  1  assembled descriptor valid.
- desc_ready_i  in  1  descriptor consumed.
- desc_o  out  NumWords*DataWidth  descriptor; word k is at bits [k*DataWidth +: DataWidth].
- done_valid_i  in  1  completion write request.
- done_ready_o  out  1  completion request accepted.
- done_addr_i  in  AddrWidth  completion word byte address.
- busy_o  out  1  high in every state except IDLE.
- reg_req_o  out  reg_req_t  register request toward the AXI bridge.
- reg_rsp_i  in  reg_rsp_t  register response from the AXI bridge.

## Operation
- States: IDLE, READ, OUT, WRITE.
- IDLE:
  - done_ready_o = done_valid_i.
  - addr_ready_o = !done_valid_i, so a completion request beats a fetch request in the same cycle.
  - done handshake: latch done_addr_i → WRITE.
  - addr handshake: latch addr_i with the low ByteWidthInPowersOfTwo bits forced to 0, clear the word counter → READ.
- READ:
  - reg_req_o.valid = 1, write = 0.
  - addr = base + cnt << ByteWidthInPowersOfTwo, computed modulo 2^AddrWidth (wraps silently).
  - When reg_rsp_i.ready is high: capture rdata into word cnt and increment cnt.
  - If cnt == NumWords-1 at that point → OUT.
  - The counter is $clog2(NumWords+1) bits wide.
- OUT:
  - desc_valid_o = 1 and desc_o is held stable.
  - On desc_ready_i → IDLE.
- WRITE:
  - reg_req_o.valid = 1, write = 1, addr = latched done address.
  - wdata = '1, wstrb = '1.
  - On reg_rsp_i.ready → IDLE.
- The request fields (valid, addr, write, wdata, wstrb) stay stable until ready is seen.
- reg_rsp_i.error is ignored.
- reg_req_o.wdata and wstrb are '0 on reads.
- No overlap between fetches: a new address is not accepted until the previous descriptor has been consumed.

## Timing
- Reset values:
  - state IDLE, counter 0, descriptor register 0.
  - desc_valid_o = 0, reg_req_o all zero, busy_o = 0, done_ready_o = 0 while done_valid_i is low.
  - addr_ready_o = !done_valid_i.
- addr_ready_o and done_ready_o are combinational from the *_valid_i inputs in IDLE. All other outputs are registered-state decodes; there is no combinational path from reg_rsp_i to reg_req_o.
- Fetch latency with a zero-wait slave (ready in the same cycle as valid):
  - address handshake at edge 0;
  - reads during cycles 1..NumWords;
  - desc_valid_o in cycle NumWords+1.
  - Each slave wait cycle adds one cycle.
- Completion write with a zero-wait slave: handshake at edge 0, write in cycle 1, IDLE in cycle 2.
- desc_valid_o stays high until desc_ready_i; it never drops without a handshake.
- Reset mid-operation drops reg_req_o.valid immediately and discards partial words. This is the only permitted protocol break.

## Structure
- Put the following in shared package dma_desc_pkg:
  - state enum fetcher_state_e {IDLE, READ, OUT, WRITE};
  - localparam DescNumWords = 4;
  - completion value constant DescDoneValue = '1.
- Single module, no sub-modules.
- Use the FF macros from common_cells/registers.svh for all state.

## Test plan
- Zero-wait memory holding 0x11,0x22,0x33,0x44 at 0x1000..0x1018; fetch 0x1000 → reads at 0x1000, 0x1008, 0x1010, 0x1018 in consecutive cycles; desc_o = {0x44,0x33,0x22,0x11}; desc_valid_o in cycle 5.
- Slave inserts 2 wait cycles on word 1 → request stays stable throughout; desc_valid_o in cycle 7; data is correct.
- desc_ready_i held low for 10 cycles → desc_o stable, addr_ready_o = 0, no reg traffic; on release, IDLE next cycle.
- done_valid_i and addr_valid_i both high in IDLE with done_addr 0x2008 → write of '1 with full strobe to 0x2008 first; the fetch is accepted after the write completes.
- Base 0x...FFF8 with NumWords = 4 → addresses wrap to 0x0, 0x8, 0x10; unaligned base 0x1003 → first read at 0x1000.
- Reset asserted during the READ of word 2 → reg valid low immediately; after release the block is IDLE, busy_o = 0, and a new fetch returns correct data.
